// File: rtl/mloop_pkg.sv
`default_nettype none
// ============================================================================
// Module  : mloop_pkg
// Brief   : FSM state encoding and default widths for the mloop_diff block.
// Revision: 1.0
// ============================================================================
package mloop_pkg;

    localparam int W_A = 16;
    localparam int W_X = 10;

    typedef logic [0:0] state_t;
    localparam state_t EMPTY = 1'b0;
    localparam state_t FULL  = 1'b1;

endpackage : mloop_pkg
`default_nettype wire

// File: rtl/rgst.sv
`default_nettype none
// ============================================================================
// Module  : rgst
// Brief   : Loadable register with async reset and synchronous clear to zero.
// Revision: 1.0
// ============================================================================
module rgst #(
    parameter int w = 16
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         clr,
    input  logic         ld,
    input  logic [w-1:0] d,
    output logic [w-1:0] q
);

    logic [w-1:0] r_q;

    // Clear wins over load so a restart always starts from zero.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_q <= '0;
        end else if (clr) begin
            r_q <= '0;
        end else if (ld) begin
            r_q <= d;
        end
    end

    assign q = r_q;

endmodule : rgst
`default_nettype wire

// File: rtl/mloop_diff.sv
`default_nettype none
// ============================================================================
// Module  : mloop_diff
// Brief   : Recovers increments from a running sum (x = a - prev) with a
//           one-deep valid/ready output stage. MLOOP_DIFF_SAT_EN selects
//           saturation of oversized increments instead of truncation.
// Revision: 1.0
// ============================================================================
module mloop_diff
    import mloop_pkg::*;
#(
    parameter int W_A = mloop_pkg::W_A,
    parameter int W_X = mloop_pkg::W_X
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           clr,
    input  logic           a_valid,
    input  logic [W_A-1:0] a,
    output logic           a_ready,
    output logic           x_valid,
    output logic [W_X-1:0] x,
    input  logic           x_ready,
    output logic           ovf
);

    state_t         r_state;
    logic [W_X-1:0] r_x;
    logic           r_ovf;
    logic [W_A-1:0] w_prev;
    logic [W_A-1:0] w_diff;
    logic           w_a_xfer;
    logic           w_x_xfer;
    logic           w_big;
    logic [W_X-1:0] w_x_next;

    assign a_ready  = ~clr & ((r_state == EMPTY) | x_ready);
    assign w_a_xfer = a_valid & a_ready;
    assign w_x_xfer = (r_state == FULL) & x_ready;

    rgst #(
        .w (W_A)
    ) u_prev (
        .clk (clk),
        .rst (rst),
        .clr (clr),
        .ld  (w_a_xfer),
        .d   (a),
        .q   (w_prev)
    );

    // Modulo subtraction: a wrap of the running sum yields a small positive step.
    assign w_diff = a - w_prev;

    generate
        if (W_A > W_X) begin : g_ovf_detect
            assign w_big = |w_diff[W_A-1:W_X];
        end else begin : g_no_ovf
            assign w_big = 1'b0;
        end
    endgenerate

`ifdef MLOOP_DIFF_SAT_EN
    assign w_x_next = w_big ? {W_X{1'b1}} : w_diff[W_X-1:0];
`else
    assign w_x_next = w_diff[W_X-1:0];
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= EMPTY;
            r_x     <= '0;
            r_ovf   <= 1'b0;
        end else if (clr) begin
            r_state <= EMPTY;
            r_x     <= '0;
            r_ovf   <= 1'b0;
        end else if (w_a_xfer) begin
            r_state <= FULL;
            r_x     <= w_x_next;
            r_ovf   <= r_ovf | w_big;
        end else if (w_x_xfer) begin
            r_state <= EMPTY;
        end
    end

    assign x_valid = (r_state == FULL);
    assign x       = r_x;
    assign ovf     = r_ovf;

endmodule : mloop_diff
`default_nettype wire
